signal_input_conditioner: RTL

SIGNAL_INPUT_CONDITIONER -- requirements
Module: signal_input_conditioner

---
 rtl/signal_input_conditioner.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/signal_input_conditioner.sv
// Pedestrian button / car sensor input conditioning: synchronizers, debouncer,
// request latch FSM and car-presence hold. Optional request timeout via REQ_TIMEOUT_EN.
module signal_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES    = 4,
    parameter int unsigned CAR_HOLD_CYCLES    = 8,
    parameter int unsigned REQ_TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_btn_raw,
    input  logic       car_raw,
    input  logic [2:0] lights,
    output logic       pedestrian_button,
    output logic       car_sensor,
    output logic       req_expired
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SERVED
    } req_state_t;

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(CAR_HOLD_CYCLES);

    logic       ped_s1, ped_s2;
    logic       car_s1, car_s2, car_d;
    logic       btn_acc, btn_acc_d;
    logic [7:0] db_cnt;
    logic [7:0] hold_cnt;
    req_state_t state;
    logic       is_red;
    logic       press;

    assign is_red = (lights == 3'b001);
    assign press  = btn_acc & ~btn_acc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_s1 <= 1'b0;
            ped_s2 <= 1'b0;
            car_s1 <= 1'b0;
            car_s2 <= 1'b0;
        end else begin
            ped_s1 <= ped_btn_raw;
            ped_s2 <= ped_s1;
            car_s1 <= car_raw;
            car_s2 <= car_s1;
        end
    end

    // Accept the new level on the cycle the mismatch count would reach DEBOUNCE_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt    <= '0;
            btn_acc   <= 1'b0;
            btn_acc_d <= 1'b0;
        end else begin
            btn_acc_d <= btn_acc;
            if (ped_s2 == btn_acc) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_acc <= ped_s2;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end
    end

    // Rising is immediate; falling stretched by the hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            car_d      <= 1'b0;
            hold_cnt   <= '0;
            car_sensor <= 1'b0;
        end else begin
            car_d <= car_s2;
            if (car_s2) begin
                hold_cnt   <= '0;
                car_sensor <= 1'b1;
            end else if (car_d) begin
                hold_cnt   <= HOLD_LOAD;
                car_sensor <= 1'b1;
            end else if (hold_cnt != '0) begin
                hold_cnt   <= hold_cnt - 8'd1;
                car_sensor <= (hold_cnt > 8'd1);
            end else begin
                car_sensor <= 1'b0;
            end
        end
    end

`ifdef REQ_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(REQ_TIMEOUT_CYCLES - 1);
    logic [9:0] tmo_cnt;

    // RED is checked before the timeout so a coincident edge resolves to SERVED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            pedestrian_button <= 1'b0;
            req_expired       <= 1'b0;
            tmo_cnt           <= '0;
        end else begin
            req_expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        state             <= PENDING;
                        pedestrian_button <= 1'b1;
                        tmo_cnt           <= '0;
                    end
                end
                PENDING: begin
                    if (is_red) begin
                        state             <= SERVED;
                        pedestrian_button <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state             <= IDLE;
                        pedestrian_button <= 1'b0;
                        req_expired       <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                SERVED: begin
                    if (!is_red) state <= IDLE;
                end
                default: begin
                    state             <= IDLE;
                    pedestrian_button <= 1'b0;
                end
            endcase
        end
    end
`else
    assign req_expired = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            pedestrian_button <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        state             <= PENDING;
                        pedestrian_button <= 1'b1;
                    end
                end
                PENDING: begin
                    if (is_red) begin
                        state             <= SERVED;
                        pedestrian_button <= 1'b0;
                    end
                end
                SERVED: begin
                    if (!is_red) state <= IDLE;
                end
                default: begin
                    state             <= IDLE;
                    pedestrian_button <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule
